qz_readback_ctrl: RTL and testbench
===================================

Name: qz_readback_ctrl

Overview:
- Readback "reader" for logic-cell flip-flop state: snapshots a parallel vector of QZ outputs from a column of logic-cell flip-flops on request.
- Streams the snapshot serially, LSB first, followed by one even-parity bit, over a valid/ready handshake.
- Sits beside the logic-cell array in the debug/readback path. Feeds the serial readback collector.

Parameters:
- WIDTH, 16, number of flip-flop QZ bits captured per snapshot (2..256)
- CNT_W, $clog2(WIDTH+1), beat counter width (derived constant, do not override)

Ports:
- QCK  input  1  clock; single clock domain
- QRT  input  1  reset; synchronous, active-high
- QZ_IN  input  WIDTH  parallel flip-flop outputs to snapshot
- CAP_REQ  input  1  capture request, sampled each QCK rising edge
- CLR_OVR  input  1  clears sticky OVERRUN
- SO  output  1  serial data bit
- SO_VALID  output  1  SO holds a valid beat
- SO_READY  input  1  downstream accepts the beat
- SO_LAST  output  1  current beat is the parity beat
- BUSY  output  1  snapshot in progress
- DONE  output  1  one-cycle pulse after parity beat accepted
- OVERRUN  output  1  sticky: CAP_REQ was dropped

Behaviour:
- Reset: QRT high at a QCK edge sets state IDLE, shadow=0, cnt=0, parity=0, and SO, SO_VALID, SO_LAST, BUSY, DONE, OVERRUN all =0. This applies mid-stream: the in-flight snapshot is discarded and nothing is emitted.
- States:
  - IDLE: SO_VALID=0, BUSY=0.
  - DATA: emit bits 0..WIDTH-1.
  - PAR: emit the parity beat.
- IDLE -> DATA when CAP_REQ=1.
  - On that edge: shadow<=QZ_IN, parity<=^QZ_IN, cnt<=0.
  - The first beat is valid the next cycle (1-cycle latency from CAP_REQ to SO_VALID).
- DATA:
  - SO=shadow[0], SO_VALID=1, SO_LAST=0.
  - Beat transfers only when SO_VALID && SO_READY. On transfer: shadow shifts right by 1 (zero fill), cnt++.
  - On transfer with cnt==WIDTH-1, go to PAR.
- PAR:
  - SO=parity, SO_VALID=1, SO_LAST=1.
  - On transfer, pulse DONE for one cycle and go to IDLE.
- SO, SO_LAST and SO_VALID hold stable while SO_VALID=1 && SO_READY=0. There is no timeout.
- Total beats per snapshot = WIDTH+1. With SO_READY tied high, a snapshot occupies WIDTH+1 consecutive cycles.
- BUSY=1 in DATA and PAR.
- Back-to-back: CAP_REQ=1 in the same cycle as the PAR transfer is accepted.
  - Capture occurs on that edge; the next state is DATA and no IDLE cycle is inserted.
  - DONE still pulses.
- CAP_REQ=1 while BUSY, other than the back-to-back case, is ignored and sets OVERRUN.
- OVERRUN clears only on QRT or CLR_OVR. If CLR_OVR and a new overrun occur in the same cycle, set wins.
- QZ_IN is sampled only on the capture edge; later changes do not affect the stream.
- DONE is registered: it is asserted the cycle after the PAR transfer edge... correction: DONE is driven from a flop set on the PAR transfer edge, so it is high for the cycle following that edge.

Decomposition:
- Shared package qz_readback_pkg holds:
  - state enum {IDLE, DATA, PAR} (2-bit encoding)
  - WIDTH bounds constants
  - CNT_W helper function
- One sub-module is natural: qz_shadow_sreg. It is a WIDTH-bit parallel-load, shift-right register with load/shift enables and a parity output computed on load.
- The FSM, counter and handshake stay in qz_readback_ctrl.

Test Plan:
- WIDTH=16, QZ_IN=16'hA5C3, CAP_REQ pulse, SO_READY=1:
  - SO sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then parity 0 with SO_LAST=1.
  - 17 valid cycles; DONE pulses once; BUSY then drops.
- Same stimulus, SO_READY toggling 1/0 each cycle:
  - Identical bit sequence; outputs stable during every stall.
  - Stream completes in 33 cycles.
- QZ_IN=16'h0001 -> parity beat 1. QZ_IN changed to 16'hFFFF after capture -> stream still shows 0001.
- CAP_REQ on beat 5 -> ignored, OVERRUN=1.
  - CLR_OVR asserted together with another mid-stream CAP_REQ -> OVERRUN stays 1.
  - CLR_OVR alone -> 0.
- CAP_REQ during the PAR transfer cycle, with a new QZ_IN=16'h8000:
  - Next cycle starts DATA with no IDLE gap.
  - First beat 0, bit 15 = 1, parity 1.
- QRT asserted on beat 7 -> next cycle all outputs 0, state IDLE, no DONE.
  - A subsequent CAP_REQ produces a full, correct 17-beat stream.

Source files
------------

// File: rtl/qz_readback_pkg.sv
// rtl/qz_readback_pkg.sv - shared types and constants for the QZ readback reader
// Purpose: FSM state encoding, WIDTH bounds and the beat-counter width helper.
package qz_readback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 256;

    // Counter must hold 0..WIDTH, hence WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/qz_readback_ctrl_if.sv
// rtl/qz_readback_ctrl_if.sv - serial readback stream interface
// Purpose: groups the serial beat handshake.
//   SO        serial data bit
//   SO_VALID  SO holds a valid beat
//   SO_READY  sink accepts the beat
//   SO_LAST   beat is the parity beat
// master = stream source (the reader), slave = stream sink (the collector).
interface qz_readback_ctrl_if;
    logic SO;
    logic SO_VALID;
    logic SO_READY;
    logic SO_LAST;

    modport master (
        output SO,
        output SO_VALID,
        output SO_LAST,
        input  SO_READY
    );

    modport slave (
        input  SO,
        input  SO_VALID,
        input  SO_LAST,
        output SO_READY
    );
endinterface

// File: rtl/qz_shadow_sreg.sv
// rtl/qz_shadow_sreg.sv - snapshot shadow register with load-time parity
// Purpose: WIDTH-bit parallel-load, shift-right (zero fill) register.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   load      capture d into the shadow and latch its even parity
//   shift     shift shadow right by one (ignored when load is set)
//   d         parallel data to capture
//   q0        shadow LSB (current serial bit)
//   parity    even parity of the last captured value
module qz_shadow_sreg
    import qz_readback_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0,
    output logic             parity
);

    logic [WIDTH-1:0] shadow_d, shadow_q;
    logic             parity_d, parity_q;

    always_comb begin
        shadow_d = shadow_q;
        parity_d = parity_q;
        if (load) begin
            shadow_d = d;
            parity_d = ^d;
        end else if (shift) begin
            shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            parity_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            parity_q <= parity_d;
        end
    end

    assign q0     = shadow_q[0];
    assign parity = parity_q;

endmodule

// File: rtl/qz_readback_ctrl.sv
// rtl/qz_readback_ctrl.sv - QZ flip-flop snapshot reader with serial parity stream
// Purpose: captures QZ_IN on CAP_REQ and streams it LSB first, then one even-parity beat.
// Ports:
//   QCK, QRT  clock, synchronous active-high reset
//   QZ_IN     parallel flip-flop outputs, sampled only on the capture edge
//   CAP_REQ   capture request
//   CLR_OVR   clears sticky OVERRUN (a same-cycle new overrun wins)
//   BUSY      snapshot in progress (DATA or PAR)
//   DONE      one-cycle pulse following the parity beat transfer
//   OVERRUN   sticky: a CAP_REQ was dropped while busy
//   so        serial stream source (SO/SO_VALID/SO_LAST out, SO_READY in)
module qz_readback_ctrl
    import qz_readback_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic                QCK,
    input  logic                QRT,
    input  logic [WIDTH-1:0]    QZ_IN,
    input  logic                CAP_REQ,
    input  logic                CLR_OVR,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVERRUN,
    qz_readback_ctrl_if.master  so
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             ovr_d, ovr_q;

    logic             so_valid;
    logic             xfer;
    logic             load;
    logic             shift;
    logic             ovr_set;
    logic             sh_bit;
    logic             sh_parity;

    qz_shadow_sreg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk    (QCK),
        .rst    (QRT),
        .load   (load),
        .shift  (shift),
        .d      (QZ_IN),
        .q0     (sh_bit),
        .parity (sh_parity)
    );

    assign so_valid = (state_q != IDLE);
    assign xfer     = so_valid && so.SO_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovr_set = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (CAP_REQ) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                ovr_set = CAP_REQ;
                if (xfer) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (xfer) begin
                    done_d = 1'b1;
                    // A request landing on the final transfer chains straight into the next snapshot.
                    if (CAP_REQ) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ovr_set = CAP_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d = (ovr_q & ~CLR_OVR) | ovr_set;
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        so.SO = 1'b0;
        if (state_q == DATA) begin
            so.SO = sh_bit;
        end else if (state_q == PAR) begin
            so.SO = sh_parity;
        end
    end

    assign so.SO_VALID = so_valid;
    assign so.SO_LAST  = (state_q == PAR);
    assign BUSY        = so_valid;
    assign DONE        = done_q;
    assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_qz_readback_ctrl.sv
// tb/tb_qz_readback_ctrl.sv - self-checking bench for qz_readback_ctrl
module tb_qz_readback_ctrl;

    localparam int WIDTH = 16;

    logic             QCK = 1'b0;
    logic             QRT;
    logic [WIDTH-1:0] QZ_IN;
    logic             CAP_REQ;
    logic             CLR_OVR;
    logic             BUSY;
    logic             DONE;
    logic             OVERRUN;

    qz_readback_ctrl_if so_if();

    qz_readback_ctrl #(.WIDTH(WIDTH)) dut (
        .QCK     (QCK),
        .QRT     (QRT),
        .QZ_IN   (QZ_IN),
        .CAP_REQ (CAP_REQ),
        .CLR_OVR (CLR_OVR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OVERRUN (OVERRUN),
        .so      (so_if)
    );

    always #5 QCK = ~QCK;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    // Model: the beats still owed for the current snapshot, front = beat on SO.
    bit m_q[$];
    bit m_ovr  = 1'b0;
    bit m_done = 1'b0;

    bit got[$];
    int valid_cnt = 0;
    int done_cnt  = 0;

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ones_odd(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
        return (n % 2) == 1;
    endfunction

    always @(negedge QCK) begin : cmp
        int  sz;
        bit  xfer;
        bit  cap_ok;
        bit  ovr_set;
        sz = m_q.size();
        if (chk_en) begin
            check_v("so_valid", so_if.SO_VALID, sz > 0);
            check_v("so_last",  so_if.SO_LAST,  sz == 1);
            check_v("busy",     BUSY,           sz > 0);
            check_v("done",     DONE,           m_done);
            check_v("overrun",  OVERRUN,        m_ovr);
            if (sz > 0) check_v("so_bit", so_if.SO, m_q[0]);
        end
        if (so_if.SO_VALID === 1'b1 && so_if.SO_READY === 1'b1) got.push_back(so_if.SO);
        if (so_if.SO_VALID === 1'b1) valid_cnt++;
        if (DONE === 1'b1) done_cnt++;

        if (QRT) begin
            m_q.delete();
            m_ovr  = 1'b0;
            m_done = 1'b0;
        end else begin
            xfer    = (sz > 0) && so_if.SO_READY;
            cap_ok  = CAP_REQ && ((sz == 0) || (sz == 1 && so_if.SO_READY));
            ovr_set = CAP_REQ && !cap_ok;
            m_done  = xfer && (sz == 1);
            if (xfer) void'(m_q.pop_front());
            if (cap_ok) begin
                for (int i = 0; i < WIDTH; i++) m_q.push_back(QZ_IN[i]);
                m_q.push_back(ones_odd(QZ_IN));
            end
            m_ovr = (m_ovr && !CLR_OVR) || ovr_set;
        end
    end

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic clear_stats();
        got.delete();
        valid_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check_v({name, "_idle"}, BUSY, 1'b0);
        tick();
    endtask

    task automatic check_stream(input string name, input logic [WIDTH:0] exp);
        logic [WIDTH:0] v = '0;
        check_v({name, "_len"}, got.size(), WIDTH + 1);
        for (int i = 0; i < got.size() && i <= WIDTH; i++) v[i] = got[i];
        check_v(name, v, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        QRT = 1'b1; CAP_REQ = 1'b0; CLR_OVR = 1'b0; QZ_IN = '0; so_if.SO_READY = 1'b1;
        repeat (3) tick();
        QRT    = 1'b0;
        chk_en = 1'b1;
        check_v("rst_valid", so_if.SO_VALID, 1'b0);
        check_v("rst_busy",  BUSY,           1'b0);
        check_v("rst_done",  DONE,           1'b0);
        check_v("rst_ovr",   OVERRUN,        1'b0);
        check_v("rst_so",    so_if.SO,       1'b0);

        // Basic stream, ready tied high.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'hA5C3;
        tick();
        CAP_REQ = 1'b0;
        wait_idle("t1");
        check_stream("t1_bits", 17'b0_1010010111000011);
        check_v("t1_valid_cycles", valid_cnt, 17);
        check_v("t1_done_pulses",  done_cnt,  1);

        // Ready toggling every cycle.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'hA5C3; so_if.SO_READY = 1'b0;
        tick();
        CAP_REQ = 1'b0;
        for (int i = 0; i < 40; i++) begin
            so_if.SO_READY = (i % 2 == 0);
            tick();
        end
        so_if.SO_READY = 1'b1;
        tick();
        check_stream("t2_bits", {1'b0, 16'hA5C3});
        check_v("t2_valid_cycles", valid_cnt, 33);
        check_v("t2_done_pulses",  done_cnt,  1);

        // QZ_IN changes after capture must not leak into the stream.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'h0001;
        tick();
        CAP_REQ = 1'b0; QZ_IN = 16'hFFFF;
        wait_idle("t3");
        check_stream("t3_bits", {1'b1, 16'h0001});

        // Overrun set, set-wins-over-clear, then clear.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'h1234;
        tick();
        CAP_REQ = 1'b0;
        repeat (5) tick();
        CAP_REQ = 1'b1;
        tick();
        CAP_REQ = 1'b0;
        check_v("ovr_set", OVERRUN, 1'b1);
        repeat (2) tick();
        CAP_REQ = 1'b1; CLR_OVR = 1'b1;
        tick();
        CAP_REQ = 1'b0; CLR_OVR = 1'b0;
        check_v("ovr_set_wins", OVERRUN, 1'b1);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        check_v("ovr_cleared", OVERRUN, 1'b0);
        check_v("ovr_still_busy", BUSY, 1'b1);
        wait_idle("t4");
        check_stream("t4_bits", {1'b1, 16'h1234});

        // Back-to-back capture on the parity transfer.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'h00FF;
        tick();
        CAP_REQ = 1'b0;
        n = 0;
        while (so_if.SO_LAST !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_v("b2b_reach_par", so_if.SO_LAST, 1'b1);
        CAP_REQ = 1'b1; QZ_IN = 16'h8000;
        tick();
        CAP_REQ = 1'b0; QZ_IN = 16'h5555;
        check_v("b2b_busy",  BUSY,           1'b1);
        check_v("b2b_valid", so_if.SO_VALID, 1'b1);
        check_v("b2b_first", so_if.SO,       1'b0);
        check_v("b2b_done",  DONE,           1'b1);
        check_stream("b2b_prev_bits", {1'b0, 16'h00FF});
        clear_stats();
        wait_idle("t5");
        check_stream("b2b_bits", {1'b1, 16'h8000});

        // Reset mid-stream, then a clean stream.
        clear_stats();
        CAP_REQ = 1'b1; QZ_IN = 16'h3C5A;
        tick();
        CAP_REQ = 1'b0;
        repeat (7) tick();
        QRT = 1'b1;
        tick();
        QRT = 1'b0;
        check_v("mrst_valid", so_if.SO_VALID, 1'b0);
        check_v("mrst_busy",  BUSY,           1'b0);
        check_v("mrst_last",  so_if.SO_LAST,  1'b0);
        check_v("mrst_so",    so_if.SO,       1'b0);
        check_v("mrst_done",  DONE,           1'b0);
        repeat (3) tick();
        check_v("mrst_no_done", done_cnt, 0);
        clear_stats();
        CAP_REQ = 1'b1;
        tick();
        CAP_REQ = 1'b0;
        wait_idle("t6");
        check_stream("mrst_bits", {1'b0, 16'h3C5A});
        check_v("mrst_done_pulses", done_cnt, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            CAP_REQ        = ($urandom_range(0, 7) == 0);
            CLR_OVR        = ($urandom_range(0, 15) == 0);
            so_if.SO_READY = ($urandom_range(0, 3) != 0);
            QRT            = ($urandom_range(0, 199) == 0);
            QZ_IN          = WIDTH'($urandom);
            tick();
        end
        CAP_REQ = 1'b0; CLR_OVR = 1'b0; QRT = 1'b0; so_if.SO_READY = 1'b1;
        wait_idle("rand");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
